// File: rtl/chrom_sched_pkg.sv
// -----------------------------------------------------------------------------
// chrom_sched_pkg
//
// Shared definitions for the chromosome evaluation scheduler:
//   - chrom_state_t : sequencing FSM states
//   - OSTATE_*      : encodings driven on the external oState status port
//   - settle_length : settle-cycle count for the 2-bit settle selector
//   - state_code    : maps an FSM state to its oState encoding
// -----------------------------------------------------------------------------
package chrom_sched_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      APPLY   = 3'd2,
      SETTLE  = 3'd3,
      SAMPLE  = 3'd4,
      DONE    = 3'd5,
      RELEASE = 3'd6
   } chrom_state_t;

   localparam logic [1:0] OSTATE_IDLE     = 2'd0;
   localparam logic [1:0] OSTATE_RUNNING  = 2'd1;
   localparam logic [1:0] OSTATE_DONE_REL = 2'd2;
   localparam logic [1:0] OSTATE_STALLED  = 2'd3;

   // Wide enough to hold the longest settle length (1024).
   localparam int SETTLE_LEN_W = 11;

   function automatic logic [SETTLE_LEN_W-1:0] settle_length(input logic [1:0] sel);
      logic [SETTLE_LEN_W-1:0] len;
      case (sel)
         2'd0:    len = 11'd16;
         2'd1:    len = 11'd64;
         2'd2:    len = 11'd256;
         default: len = 11'd1024;
      endcase
      return len;
   endfunction

   function automatic logic [1:0] state_code(input chrom_state_t s);
      logic [1:0] code;
      case (s)
         IDLE:          code = OSTATE_IDLE;
         DONE, RELEASE: code = OSTATE_DONE_REL;
         default:       code = OSTATE_RUNNING;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/chrom_eval_scheduler_if.sv
// -----------------------------------------------------------------------------
// chrom_eval_scheduler_if
//
// Bundles the HPS handshake, the test-vector mux and the chromosome-circuit
// signals of the evaluation scheduler. Member names keep the established
// i/o-prefixed names of the HPS register map.
//
// Modports:
//   master : HPS / vector-mux / circuit side (drives the i* members)
//   slave  : scheduler side (drives the o* members)
//
// Members:
//   iStart, iDoneFeedback, iStall      HPS control levels
//   iSequencesToProcess[7:0]           number of sequences N
//   iSettleSelector[1:0]               settle length selector
//   oSeqIndex[7:0]                     current vector index to the mux
//   iInputSequence/iExpectedOutput/iValidOutput[7:0]  vector data
//   oCircuitReset, oCircuitInput[7:0]  drive to the chromosome circuit
//   iCircuitOutput[NUM_OUTPUTS-1:0]    circuit response
//   oErrorSums[NUM_OUTPUTS*SUM_W-1:0]  packed mismatch counters
//   oReadyToProcess, oDoneProcessing, oState[1:0]  status
// -----------------------------------------------------------------------------
interface chrom_eval_scheduler_if #(
   parameter int NUM_OUTPUTS = 8,
   parameter int SUM_W       = 32
);
   logic                         iStart;
   logic                         iDoneFeedback;
   logic                         iStall;
   logic [7:0]                   iSequencesToProcess;
   logic [1:0]                   iSettleSelector;
   logic [7:0]                   oSeqIndex;
   logic [7:0]                   iInputSequence;
   logic [7:0]                   iExpectedOutput;
   logic [7:0]                   iValidOutput;
   logic                         oCircuitReset;
   logic [7:0]                   oCircuitInput;
   logic [NUM_OUTPUTS-1:0]       iCircuitOutput;
   logic [NUM_OUTPUTS*SUM_W-1:0] oErrorSums;
   logic                         oReadyToProcess;
   logic                         oDoneProcessing;
   logic [1:0]                   oState;

   modport master (
      output iStart, iDoneFeedback, iStall, iSequencesToProcess, iSettleSelector,
             iInputSequence, iExpectedOutput, iValidOutput, iCircuitOutput,
      input  oSeqIndex, oCircuitReset, oCircuitInput, oErrorSums,
             oReadyToProcess, oDoneProcessing, oState
   );

   modport slave (
      input  iStart, iDoneFeedback, iStall, iSequencesToProcess, iSettleSelector,
             iInputSequence, iExpectedOutput, iValidOutput, iCircuitOutput,
      output oSeqIndex, oCircuitReset, oCircuitInput, oErrorSums,
             oReadyToProcess, oDoneProcessing, oState
   );

endinterface

// File: rtl/chrom_error_accumulator.sv
// -----------------------------------------------------------------------------
// chrom_error_accumulator
//
// NUM_OUTPUTS saturating SUM_W-bit mismatch counters. While iEnable is high,
// counter i increments when iValid[i] is set and iActual[i] differs from
// iExpected[i]. iClear zeroes every counter and has priority over iEnable.
//
// Ports:
//   iClock, iReset           clock, synchronous active-high reset
//   iClear                   zero all counters
//   iEnable                  accumulate this cycle
//   iValid, iExpected, iActual [NUM_OUTPUTS-1:0]  compare mask / reference / DUT
//   oSums [NUM_OUTPUTS*SUM_W-1:0]  counter i at [i*SUM_W +: SUM_W]
// -----------------------------------------------------------------------------
module chrom_error_accumulator #(
   parameter int NUM_OUTPUTS = 8,
   parameter int SUM_W       = 32
) (
   input  logic                         iClock,
   input  logic                         iReset,
   input  logic                         iClear,
   input  logic                         iEnable,
   input  logic [NUM_OUTPUTS-1:0]       iValid,
   input  logic [NUM_OUTPUTS-1:0]       iExpected,
   input  logic [NUM_OUTPUTS-1:0]       iActual,
   output logic [NUM_OUTPUTS*SUM_W-1:0] oSums
);

   logic [SUM_W-1:0] sums [NUM_OUTPUTS];

   // NOTE: the counters are individual flip-flops read by the HPS, not a RAM,
   // so every entry is reset; a RAM-style array would be left unreset.
   always_ff @(posedge iClock) begin
      if (iReset || iClear) begin
         for (int i = 0; i < NUM_OUTPUTS; i++) sums[i] <= '0;
      end else if (iEnable) begin
         for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (iValid[i] && (iActual[i] != iExpected[i]) && (sums[i] != '1))
               sums[i] <= sums[i] + SUM_W'(1);
         end
      end
   end

   always_comb begin
      oSums = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) oSums[i*SUM_W +: SUM_W] = sums[i];
   end

endmodule

// File: rtl/chrom_eval_scheduler.sv
// -----------------------------------------------------------------------------
// chrom_eval_scheduler
//
// Evaluates one chromosome-configured circuit against the first N HPS test
// vectors. Per sequence: CLEAR (circuit reset, index presented to the vector
// mux), APPLY (vector latched), SETTLE (S cycles), SAMPLE (SAMPLE_CYCLES
// cycles of masked mismatch accumulation). Then DONE / RELEASE handshake.
// Per-sequence cost is 2 + S + SAMPLE_CYCLES cycles.
//
// Ports:
//   iClock   system clock
//   iReset   synchronous active-high reset
//   bus      chrom_eval_scheduler_if.slave (handshake, vector mux, circuit)
//
// Parameters:
//   NUM_OUTPUTS   circuit output bits / counters (at most 8, the vector width)
//   SAMPLE_CYCLES sampling window per sequence (>= 1)
//   SUM_W         error-sum width
//
// Build option:
//   CHROM_SCHED_STALL_EN  when defined, iStall freezes FSM, counters and sums
//                         in CLEAR/APPLY/SETTLE/SAMPLE and oState reads 3.
//                         When undefined, iStall is ignored.
// -----------------------------------------------------------------------------
module chrom_eval_scheduler
   import chrom_sched_pkg::*;
#(
   parameter int NUM_OUTPUTS   = 8,
   parameter int SAMPLE_CYCLES = 16,
   parameter int SUM_W         = 32
) (
   input  logic                   iClock,
   input  logic                   iReset,
   chrom_eval_scheduler_if.slave  bus
);

   // One counter serves both the settle and the sample phase.
   localparam int CNT_W = (SAMPLE_CYCLES > 1024) ? $clog2(SAMPLE_CYCLES) : SETTLE_LEN_W;

   chrom_state_t           state;
   logic [7:0]             num_seq;
   logic [1:0]             settle_sel;
   logic [CNT_W-1:0]       cnt;
   logic [7:0]             seq_index;
   logic [NUM_OUTPUTS-1:0] expected_q;
   logic [NUM_OUTPUTS-1:0] valid_q;
   logic [7:0]             circuit_input;
   logic                   circuit_reset;
   logic                   ready;
   logic                   done;
   logic [1:0]             state_out;

   logic                   running;
   logic                   stall_active;
   logic                   sum_clear;
   logic                   sum_enable;

   assign running = (state == CLEAR) || (state == APPLY) ||
                    (state == SETTLE) || (state == SAMPLE);

`ifdef CHROM_SCHED_STALL_EN
   assign stall_active = bus.iStall && running;
`else
   assign stall_active = 1'b0;
`endif

   assign sum_clear  = (state == IDLE) && bus.iStart;
   assign sum_enable = (state == SAMPLE) && !stall_active;

   // Every transition goes through here so the status outputs are registered
   // alongside the state and always describe the state being entered.
   task goto(input chrom_state_t s);
      state         <= s;
      ready         <= (s == IDLE);
      done          <= (s == DONE);
      circuit_reset <= (s == CLEAR);
      state_out     <= state_code(s);
   endtask

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state         <= IDLE;
         ready         <= 1'b1;
         done          <= 1'b0;
         circuit_reset <= 1'b0;
         state_out     <= OSTATE_IDLE;
         num_seq       <= '0;
         settle_sel    <= '0;
         cnt           <= '0;
         seq_index     <= '0;
         expected_q    <= '0;
         valid_q       <= '0;
         circuit_input <= '0;
      end else begin
         // Default status for a cycle with no transition; goto() overrides.
         state_out <= state_code(state);
         if (stall_active) begin
            state_out <= OSTATE_STALLED;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.iStart) begin
                     num_seq    <= bus.iSequencesToProcess;
                     settle_sel <= bus.iSettleSelector;
                     seq_index  <= '0;
                     if (bus.iSequencesToProcess == 8'd0) goto(DONE);
                     else                                 goto(CLEAR);
                  end
               end
               CLEAR: goto(APPLY);
               APPLY: begin
                  circuit_input <= bus.iInputSequence;
                  expected_q    <= bus.iExpectedOutput[NUM_OUTPUTS-1:0];
                  valid_q       <= bus.iValidOutput[NUM_OUTPUTS-1:0];
                  cnt           <= CNT_W'(settle_length(settle_sel)) - CNT_W'(1);
                  goto(SETTLE);
               end
               SETTLE: begin
                  if (cnt == '0) begin
                     cnt <= CNT_W'(SAMPLE_CYCLES - 1);
                     goto(SAMPLE);
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               SAMPLE: begin
                  if (cnt == '0) begin
                     if (seq_index == num_seq - 8'd1) begin
                        goto(DONE);
                     end else begin
                        seq_index <= seq_index + 8'd1;
                        goto(CLEAR);
                     end
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
               DONE: begin
                  if (bus.iDoneFeedback) goto(RELEASE);
               end
               RELEASE: begin
                  if (!bus.iStart && !bus.iDoneFeedback) goto(IDLE);
               end
               default: goto(IDLE);
            endcase
         end
      end
   end

   chrom_error_accumulator #(
      .NUM_OUTPUTS (NUM_OUTPUTS),
      .SUM_W       (SUM_W)
   ) u_accumulator (
      .iClock    (iClock),
      .iReset    (iReset),
      .iClear    (sum_clear),
      .iEnable   (sum_enable),
      .iValid    (valid_q),
      .iExpected (expected_q),
      .iActual   (bus.iCircuitOutput),
      .oSums     (bus.oErrorSums)
   );

   assign bus.oSeqIndex       = seq_index;
   assign bus.oCircuitReset   = circuit_reset;
   assign bus.oCircuitInput   = circuit_input;
   assign bus.oReadyToProcess = ready;
   assign bus.oDoneProcessing = done;
   assign bus.oState          = state_out;

endmodule

// File: doc/chrom_eval_scheduler.md
# chrom_eval_scheduler

Sequences evaluation of one chromosome-configured genetic circuit against the HPS-supplied test vectors. For each of the first N input sequences, the block:
- resets the circuit,
- applies the input byte,
- waits a selectable settle time,
- samples the circuit output over a fixed window and accumulates per-output-bit mismatch counts.

It sits between the HPS PIO handshake registers (start/ready/done/done-feedback) and the chromosome circuit datapath. It replaces ad-hoc sequencing inside the top-level processing state machine.

## Interface
Parameters:
- NUM_OUTPUTS, 8, circuit output bits and error-sum count
- SAMPLE_CYCLES, 16, sampling window length per sequence (≥1)
- SUM_W, 32, error-sum width

Ports:
- iClock  in  1  system clock (CLOCK_50 domain)
- iReset  in  1  synchronous, active-high reset
- iStart  in  1  HPS start request (level)
- iDoneFeedback  in  1  HPS acknowledge of oDone (level)
- iStall  in  1  freeze request (see Configuration)
- iSequencesToProcess  in  8  N, number of sequences, captured at start
- iSettleSelector  in  2  settle length S: 0→16, 1→64, 2→256, 3→1024 cycles, captured at start
- oSeqIndex  out  8  index of current sequence; external mux returns the vector data below
- iInputSequence  in  8  input byte for oSeqIndex
- iExpectedOutput  in  8  expected output for oSeqIndex
- iValidOutput  in  8  per-bit compare mask for oSeqIndex
- oCircuitReset  out  1  reset to the chromosome circuit
- oCircuitInput  out  8  stimulus to the circuit
- iCircuitOutput  in  NUM_OUTPUTS  circuit output
- oErrorSums  out  NUM_OUTPUTS*SUM_W  packed sums; bit i occupies [i*SUM_W +: SUM_W]
- oReadyToProcess  out  1  high only in IDLE
- oDoneProcessing  out  1  high in DONE
- oState  out  2  0 idle, 1 running, 2 done/release, 3 stalled

## Operation
- Reset values:
  - FSM=IDLE, oReadyToProcess=1, all other outputs 0, sums 0.
- IDLE:
  - On iStart=1, capture N and S, clear all sums and index.
  - If N=0, go to DONE; otherwise go to CLEAR.
  - iDoneFeedback is ignored in IDLE.
- CLEAR (1 cycle):
  - oCircuitReset=1, oSeqIndex valid.
  - Vector data is required valid by the next cycle.
- APPLY (1 cycle):
  - Latch input, expected and valid into registers.
  - oCircuitInput = latched input.
  - oCircuitReset=0.
- SETTLE (S cycles):
  - Count only; no comparison.
- SAMPLE (SAMPLE_CYCLES cycles):
  - Every cycle, for each bit i with valid[i]=1 and iCircuitOutput[i]≠expected[i], increment sum[i].
  - Sums saturate at all-ones.
  - On the last sample cycle: if index=N-1, go to DONE; else increment index and go to CLEAR.
- DONE:
  - oDoneProcessing=1 and oErrorSums held stable.
  - On iDoneFeedback=1, go to RELEASE.
- RELEASE:
  - oDoneProcessing=0.
  - Wait for iStart=0 and iDoneFeedback=0, then go to IDLE.
- iStart outside IDLE is ignored. Changes to iSequencesToProcess or iSettleSelector after capture have no effect.
- oCircuitInput holds its last value in DONE/RELEASE/IDLE until the next APPLY.
- iReset mid-run: immediate return to reset values, with oCircuitReset=0 and the sums cleared.

## Timing
- Per-sequence cost: 2 + S + SAMPLE_CYCLES cycles.
- Start latency: the cycle after iStart is sampled in IDLE, FSM is in CLEAR and oReadyToProcess=0.
- Total run: with start sampled at cycle t, DONE is entered at t + 1 + N·(2+S+SAMPLE_CYCLES).
- Sums update registered: visible one cycle after the sampled mismatch.
- oSeqIndex changes only on the CLEAR entry edge.

## Configuration
- CHROM_SCHED_STALL_EN defined:
  - While iStall=1 in CLEAR/APPLY/SETTLE/SAMPLE, the FSM, counters and sums freeze and oState=3.
  - A frozen SAMPLE cycle does not accumulate.
  - Release resumes at the exact counter position.
- CHROM_SCHED_STALL_EN undefined:
  - iStall is ignored, oState never equals 3, and the stall logic is absent.

## Structure
- Shared package chrom_sched_pkg holds:
  - the state enum (IDLE, CLEAR, APPLY, SETTLE, SAMPLE, DONE, RELEASE),
  - the oState encoding constants,
  - the settle-length lookup function for the selector.
- One sub-module, chrom_error_accumulator, holds NUM_OUTPUTS saturating SUM_W counters with clear, enable, valid-mask, expected and actual inputs.
- The FSM, index counter and settle/sample counter stay in chrom_eval_scheduler.

## Test plan
- Pass case: N=1, selector 0, SAMPLE_CYCLES=16, output forced equal to expected. oDoneProcessing rises 35 cycles after start is sampled, and all sums are 0.
- Masked mismatch: N=1, expected=0x00, output=0xFF, valid=0x0F.
  - sum[0..3]=16, sum[4..7]=0.
- Multi-sequence: N=3, output constant 0x01, expected 0x00/0x01/0x00, valid 0xFF. sum[0]=32, others 0, and oSeqIndex steps 0→1→2 with oCircuitReset pulsing once per sequence.
- N=0: start → DONE next cycle with sums 0. Holding iDoneFeedback=1 then dropping iStart/iDoneFeedback returns the FSM to IDLE with oReadyToProcess=1.
- Reset mid-SETTLE on sequence 1 of N=3: the next cycle shows all outputs at reset values, and a new start runs from index 0.
- With CHROM_SCHED_STALL_EN: iStall=1 for 10 cycles mid-SAMPLE (all bits mismatching) lengthens the run by exactly 10 cycles, sums are unchanged from the no-stall run, and oState=3 during the stall.
